// File: rtl/dmem_responder.sv
// Multi-cycle data memory target: one request at a time, WAIT_CYCLES wait states, then a held response.
// Response WAIT_CYCLES+1 cycles after accept; req_ready only in IDLE, response held until rsp_ready. Optional DMEM_RSP_ERR_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
`ifdef DMEM_RSP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] mem [DEPTH_WORDS];

  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;

  logic        accept;
  logic        commit;
  logic        op_we;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [3:0]  op_be;
  logic [AW-1:0] idx;
  logic        addr_err;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid && req_ready;
  assign commit    = (state_nxt == S_RESP) && (state != S_RESP);

  // With no wait states the commit edge is the accept edge, so use the live request.
  assign op_we    = (state == S_IDLE) ? req_we    : lat_we;
  assign op_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
  assign op_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;
  assign op_be    = (state == S_IDLE) ? req_be    : lat_be;
  assign idx      = op_addr[AW+1:2];
  assign addr_err = ERR_EN && ((op_addr[1:0] != 2'b00) || (|(op_addr >> (AW + 2))));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_INIT;
          end else begin
            state_nxt = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
    end else if (accept) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < DEPTH_WORDS; w++) mem[w] <= 32'd0;
    end else if (commit && op_we && !addr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (op_be[i]) mem[idx][8*i +: 8] <= op_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_rdata <= (op_we || addr_err) ? 32'd0 : mem[idx];
      rsp_err   <= addr_err;
    end else if ((state == S_RESP) && rsp_ready) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) checked against a word-array model.
module tb_dmem_responder;

  localparam int DW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [1:0]       req_valid, req_we, rsp_ready;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0][3:0]  req_be;
  wire  [1:0]       req_ready, rsp_valid, rsp_err, busy;
  wire  [1:0][31:0] rsp_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned mem_m [2][DW];

  dmem_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  dmem_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
`ifdef DMEM_RSP_ERR_EN
    return (a % 4 != 0) || (a >= 32'(DW * 4));
`else
    return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < DW; w++) mem_m[d][w] = 0;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = '1;
  endtask

  // Asserted at a negedge, so it may land in the middle of an access.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    clear_model();
    #2;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_rsp_valid%0d", d), 32'(rsp_valid[d]), 0);
      chk($sformatf("rst_rdata%0d", d), rsp_rdata[d], 0);
      chk($sformatf("rst_err%0d", d), 32'(rsp_err[d]), 0);
      chk($sformatf("rst_busy%0d", d), 32'(busy[d]), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk($sformatf("rst_req_ready%0d", d), 32'(req_ready[d]), 1);
  endtask

  task automatic do_txn(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int stall, input bit junk);
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          w;
    int          lat;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata; req_be[d] = be;
    rsp_ready[d] = (stall == 0);
    chk("idle_req_ready", 32'(req_ready[d]), 1);
    @(posedge clk);
    #1;
    if (junk) begin
      req_we[d] = ~we; req_addr[d] = $urandom; req_wdata[d] = $urandom; req_be[d] = 4'hF;
    end else begin
      req_valid[d] = 1'b0;
    end
    chk("acc_busy", 32'(busy[d]), 1);
    chk("acc_req_ready", 32'(req_ready[d]), 0);

    exp_err = addr_bad(addr);
    w = int'((addr / 4) % DW);
    exp_rdata = (we || exp_err) ? 32'd0 : mem_m[d][w];
    if (we && !exp_err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem_m[d][w] = (mem_m[d][w] & ~(32'hFF << (8*i))) | (wdata & (32'hFF << (8*i)));

    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(wait_of(d) + 1));
    chk("rdata", rsp_rdata[d], exp_rdata);
    chk("err", 32'(rsp_err[d]), 32'(exp_err));

    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", 32'(rsp_valid[d]), 1);
      chk("stall_rdata", rsp_rdata[d], exp_rdata);
      chk("stall_req_ready", 32'(req_ready[d]), 0);
    end

    @(negedge clk);
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    chk("done_valid", 32'(rsp_valid[d]), 0);
    chk("done_rdata", rsp_rdata[d], 0);
    chk("done_err", 32'(rsp_err[d]), 0);
    chk("done_req_ready", 32'(req_ready[d]), 1);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    do_reset();

    // Load after reset, then a partial-lane store read back.
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    do_txn(0, 1'b1, 32'h20, 32'hDEADBEEF, 4'b0101, 0, 1'b0);
    do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);
    chk("partial_store_model", mem_m[0][8], 32'h00AD00EF);

    // Back-pressure with a competing request held high.
    do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 5, 1'b1);

    // Zero wait states.
    do_txn(1, 1'b1, 32'h4, 32'h12345678, 4'hF, 0, 1'b0);
    do_txn(1, 1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b0);

    // Empty byte-enable store leaves the word alone.
    do_txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1, 1'b0);
    do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);

    // Reset during the wait states of a store.
    do_txn(0, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 0, 1'b0);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h8; req_wdata[0] = 32'h0BADC0DE; req_be[0] = 4'hF;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    chk("inflight_busy", 32'(busy[0]), 1);
    do_reset();
    do_txn(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b0);

    // Misaligned, out-of-range address.
    do_txn(0, 1'b1, 32'h0, 32'h55AA55AA, 4'hF, 0, 1'b0);
    do_txn(0, 1'b0, 32'h402, 32'h0, 4'h0, 0, 1'b0);
    do_txn(0, 1'b1, 32'h402, 32'h11111111, 4'hF, 0, 1'b0);
    do_txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      int          d;
      logic [31:0] a;
      d = int'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = ($urandom_range(0, 15) << 2) | 32'($urandom_range(1, 3));
        default: a = $urandom_range(0, 15) << 2;
      endcase
      do_txn(d, 1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
